// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
//   Sequential signed multiply / divide unit feeding the Z register pair.
//   Multiply uses radix-2 Booth (WIDTH iterations); divide uses non-restoring
//   division on operand magnitudes followed by a one-cycle sign fixup.
//
//   Build option: define MULDIV_DIV_EN to include the divide path. When it is
//   undefined, a divide request completes immediately with zero results.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   launch request, sampled only in IDLE
//   op           in   0 = multiply, 1 = divide
//   a            in   multiplicand / dividend (two's complement)
//   b            in   multiplier / divisor (two's complement)
//   busy         out  high while an operation is iterating
//   done         out  one-cycle pulse, results valid from this cycle
//   div_by_zero  out  sticky flag for the last operation
//   zhigh        out  product high word / remainder
//   zlow         out  product low word / quotient
//
// State table
//   S_IDLE  | waiting for start
//   S_MUL   | Booth iterations
//   S_DIV   | non-restoring divide iterations
//   S_FIXUP | remainder restore, sign correction, divide-by-zero results
//   S_DONE  | done pulse, return to idle
// ----------------------------------------------------------------------------
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] zhigh,
   output logic [WIDTH-1:0] zlow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TC = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIXUP,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
   logic [WIDTH-1:0] r_zhigh;
   logic [WIDTH-1:0] r_zlow;

   // Booth datapath. The accumulator carries one guard bit so that
   // subtracting the most negative multiplicand cannot overflow.
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_q;
   logic             r_qm1;
   logic [WIDTH-1:0] r_mcand;

   logic [WIDTH:0]   w_mext;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_acc_n;
   logic [WIDTH-1:0] w_q_n;

   always_comb begin
      w_mext = {r_mcand[WIDTH-1], r_mcand};
      case ({r_q[0], r_qm1})
         2'b01:   w_sum = r_acc + w_mext;
         2'b10:   w_sum = r_acc - w_mext;
         default: w_sum = r_acc;
      endcase
      w_acc_n = {w_sum[WIDTH], w_sum[WIDTH:1]};
      w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
   end

`ifdef MULDIV_DIV_EN
   // Partial remainder needs two extra bits: it spans [-2D, 2D) after the
   // shift, and D itself may be 2^(WIDTH-1).
   logic [WIDTH+1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvsr;
   logic             r_neg_q;
   logic             r_neg_r;

   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_dext;
   logic [WIDTH+1:0] w_rem_n;
   logic [WIDTH-1:0] w_quo_n;
   logic [WIDTH-1:0] w_rem_mag;
   logic [WIDTH-1:0] w_q_final;
   logic [WIDTH-1:0] w_r_final;

   always_comb begin
      w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
      w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;
      w_shift = {r_rem[WIDTH:0], r_quo[WIDTH-1]};
      w_dext  = {2'b00, r_dvsr};
      w_rem_n = r_rem[WIDTH+1] ? (w_shift + w_dext) : (w_shift - w_dext);
      w_quo_n = {r_quo[WIDTH-2:0], ~w_rem_n[WIDTH+1]};
      // Final remainder is below the divisor, so WIDTH-bit arithmetic suffices.
      w_rem_mag = r_rem[WIDTH+1] ? (r_rem[WIDTH-1:0] + r_dvsr) : r_rem[WIDTH-1:0];
      w_q_final = r_neg_q ? (~r_quo + 1'b1) : r_quo;
      w_r_final = r_neg_r ? (~w_rem_mag + 1'b1) : w_rem_mag;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_zhigh <= '0;
         r_zlow  <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_qm1   <= 1'b0;
         r_mcand <= '0;
`ifdef MULDIV_DIV_EN
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvsr  <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_cnt   <= '0;
                  r_dbz   <= 1'b0;
                  r_mcand <= a;
                  if (!op) begin
                     r_acc   <= '0;
                     r_q     <= b;
                     r_qm1   <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= S_MUL;
                  end else begin
`ifdef MULDIV_DIV_EN
                     r_rem   <= '0;
                     r_quo   <= w_abs_a;
                     r_dvsr  <= w_abs_b;
                     r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                     r_neg_r <= a[WIDTH-1];
                     r_busy  <= 1'b1;
                     if (b == '0) begin
                        r_dbz   <= 1'b1;
                        r_state <= S_FIXUP;
                     end else begin
                        r_state <= S_DIV;
                     end
`else
                     r_zhigh <= '0;
                     r_zlow  <= '0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
`endif
                  end
               end
            end

            S_MUL: begin
               r_acc <= w_acc_n;
               r_q   <= w_q_n;
               r_qm1 <= r_q[0];
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CNT_TC) begin
                  r_zhigh <= w_acc_n[WIDTH-1:0];
                  r_zlow  <= w_q_n;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end

`ifdef MULDIV_DIV_EN
            S_DIV: begin
               r_rem <= w_rem_n;
               r_quo <= w_quo_n;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CNT_TC) begin
                  r_state <= S_FIXUP;
               end
            end

            S_FIXUP: begin
               if (r_dbz) begin
                  r_zhigh <= r_mcand;
                  r_zlow  <= '1;
               end else begin
                  r_zhigh <= w_r_final;
                  r_zlow  <= w_q_final;
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
`endif

            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign zhigh       = r_zhigh;
   assign zlow        = r_zlow;

endmodule

// File: tb/tb_mul_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed and randomized checks of mul_div_unit against a reference model
//   built from plain signed arithmetic (product, truncating quotient, remainder
//   with the dividend's sign). Divide expectations follow the MULDIV_DIV_EN
//   build option so the same bench covers both configurations.
// ----------------------------------------------------------------------------
module tb_mul_div_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        tb_op = 1'b0;
   logic [31:0] tb_a  = '0;
   logic [31:0] tb_b  = '0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] zhigh;
   logic [31:0] zlow;

   int vectors     = 0;
   int miscompares = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (tb_op),
      .a           (tb_a),
      .b           (tb_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .zhigh       (zhigh),
      .zlow        (zlow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: expected results, latency in cycles after acceptance.
   task automatic model(input bit op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] exh, output logic [31:0] exl,
                        output logic exdbz, output int exlat);
      longint      sa, sb, p, q, r;
      logic [63:0] pv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      exdbz = 1'b0;
      if (!op) begin
         p = sa * sb;
         pv = p;
         exh = pv[63:32];
         exl = pv[31:0];
         exlat = 33;
      end else begin
`ifdef MULDIV_DIV_EN
         if (sb == 0) begin
            exh = a;
            exl = 32'hFFFF_FFFF;
            exdbz = 1'b1;
            exlat = 2;
         end else begin
            q = sa / sb;
            r = sa % sb;
            exl = q[31:0];
            exh = r[31:0];
            exlat = 34;
         end
`else
         exh = '0;
         exl = '0;
         exlat = 1;
`endif
      end
   endtask

   // Drive a request so the next rising edge accepts it, then return #1 after
   // that edge, which is the sample point of cycle 1.
   task automatic launch(input bit op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      start = 1'b1;
      tb_op = op;
      tb_a  = a;
      tb_b  = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      tb_op = 1'($urandom);
      tb_a  = $urandom;
      tb_b  = $urandom;
   endtask

   // Wait for done with a cycle budget. Optionally pulses start for one cycle
   // at cycle 'inject' with unrelated operands, which must be ignored.
   task automatic wait_done(input int inject, output int lat, output bit busy_bad);
      lat = 0;
      busy_bad = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (done) begin
            lat = c;
            if (busy) busy_bad = 1'b1;
            break;
         end
         if (!busy) busy_bad = 1'b1;
         if (c == inject) begin
            start = 1'b1;
            tb_op = 1'b0;
            tb_a  = $urandom;
            tb_b  = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clock);
         #1;
      end
      start = 1'b0;
   endtask

   task automatic do_op(input string tag, input bit op, input logic [31:0] a,
                        input logic [31:0] b, input int inject);
      logic [31:0] exh, exl;
      logic        exdbz;
      int          exlat, lat;
      bit          busy_bad;
      model(op, a, b, exh, exl, exdbz, exlat);
      launch(op, a, b);
      if (exlat == 1) begin
         lat = done ? 1 : 0;
         busy_bad = busy;
      end else begin
         wait_done(inject, lat, busy_bad);
      end
      chk({tag, ".latency"}, 64'(lat), 64'(exlat));
      chk({tag, ".busy"}, 64'(busy_bad), 64'd0);
      chk({tag, ".zhigh"}, 64'(zhigh), 64'(exh));
      chk({tag, ".zlow"}, 64'(zlow), 64'(exl));
      chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exdbz));
      @(posedge clock);
      #1;
      chk({tag, ".done_pulse"}, 64'(done), 64'd0);
      chk({tag, ".hold_zlow"}, 64'(zlow), 64'(exl));
   endtask

   initial begin
      logic [31:0] ra, rb, exh, exl;
      logic        exdbz;
      int          exlat;
      bit          seen;

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.dbz", 64'(div_by_zero), 64'd0);
      chk("reset.zhigh", 64'(zhigh), 64'd0);
      chk("reset.zlow", 64'(zlow), 64'd0);

      do_op("mul_7x-3", 1'b0, 32'd7, -32'sd3, 0);
      do_op("mul_minxmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
      do_op("mul_maxx2", 1'b0, 32'h7FFF_FFFF, 32'd2, 0);
      do_op("mul_min_x_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

      do_op("div_m17_5", 1'b1, -32'sd17, 32'd5, 0);
      do_op("div_17_m5", 1'b1, 32'd17, -32'sd5, 0);
      do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op("div_by_zero", 1'b1, 32'h0000_1234, 32'd0, 0);
      do_op("mul_after_dbz", 1'b0, 32'd12, 32'd11, 0);
      do_op("div_100_7", 1'b1, 32'd100, 32'd7, 0);

      do_op("mul_ignore_start", 1'b0, 32'd7, -32'sd3, 10);

      // Start held through the done cycle must be ignored.
      model(1'b0, 32'd5, 32'd9, exh, exl, exdbz, exlat);
      launch(1'b0, 32'd5, 32'd9);
      wait_done(0, exlat, seen);
      start = 1'b1;
      tb_op = 1'b0;
      tb_a  = 32'd3;
      tb_b  = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(posedge clock);
      #1;
      chk("b2b.busy", 64'(busy), 64'd0);
      chk("b2b.zlow", 64'(zlow), 64'(exl));

      // Reset in cycle 15 of a multiply aborts it without a done pulse.
      launch(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (14) begin
         @(posedge clock);
         #1;
      end
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rst_mid.busy", 64'(busy), 64'd0);
      chk("rst_mid.done", 64'(done), 64'd0);
      chk("rst_mid.zhigh", 64'(zhigh), 64'd0);
      chk("rst_mid.zlow", 64'(zlow), 64'd0);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done || busy) seen = 1'b1;
      end
      chk("rst_mid.no_done", 64'(seen), 64'd0);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 6 == 5) rb = 32'($urandom_range(0, 3)) - 32'd1;
         do_op("rand", 1'(i % 2), ra, rb, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
